// File: rtl/fir_out_decim.sv
// FIR output back-end: warm-up discard, decimation by DECIM, round/saturate to OUT_W, output FIFO.
// Optional macro FIR_OUT_DECIM_AVG_EN replaces sample picking by block averaging over DECIM samples.
module fir_out_decim #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  din,
  input  logic                    din_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    sat,
  output logic                    overflow,
  input  logic                    clr_flags
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int WC_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [IN_W:0] RND  = $signed({{IN_W{1'b0}}, 1'b1} << (SHIFT - 1));
  localparam logic signed [IN_W:0] MAXV = $signed({{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  if (DECIM < 1 || DECIM > 256) begin : g_bad_decim
    $error("fir_out_decim: DECIM must be in 1..256");
  end
  if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_out_decim: FIFO_DEPTH must be a power of 2");
  end

  // Rounding add is done one bit wider than the input so it can never wrap.
  function automatic logic [OUT_W-1:0] requant(input logic signed [IN_W-1:0] x, output logic clip);
    logic signed [IN_W:0] r;
    r = ($signed({x[IN_W-1], x}) + RND) >>> SHIFT;
    if (r > MAXV) begin
      requant = MAXV[OUT_W-1:0];
      clip    = 1'b1;
    end else if (r < MINV) begin
      requant = MINV[OUT_W-1:0];
      clip    = 1'b1;
    end else begin
      requant = r[OUT_W-1:0];
      clip    = 1'b0;
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) ptr_inc = '0;
    else                             ptr_inc = p + PTR_W'(1);
  endfunction

  logic [WC_W-1:0]         warm_q, warm_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    take_s, last_s, sel_s, clip_s;
  logic signed [IN_W-1:0]  pick_s;
  logic signed [OUT_W-1:0] rq_s, stg_q, dout_q, dout_d, head_s;
  logic                    stg_vld_q, dout_valid_q, sat_q, sat_d, ovf_q, ovf_d;
  logic signed [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    full_s, pop_s, push_s, drop_s;

`ifdef FIR_OUT_DECIM_AVG_EN
  localparam int ACC_W = IN_W + 8;
  localparam int LOG2D = $clog2(DECIM);
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_s;

  if ((DECIM & (DECIM - 1)) != 0) begin : g_bad_avg
    $error("fir_out_decim: averaging requires DECIM to be a power of 2");
  end
`endif

  always_comb begin
    take_s  = din_valid && (warm_q == WC_W'(WARMUP));
    last_s  = (phase_q == PH_W'(DECIM - 1));
    warm_d  = warm_q;
    phase_d = phase_q;
    if (din_valid && !take_s) warm_d = warm_q + WC_W'(1);
    if (take_s) phase_d = last_s ? '0 : phase_q + PH_W'(1);
`ifdef FIR_OUT_DECIM_AVG_EN
    sum_s  = acc_q + {{(ACC_W - IN_W){din[IN_W-1]}}, din};
    acc_d  = acc_q;
    if (take_s) acc_d = last_s ? '0 : sum_s;
    sel_s  = take_s && last_s;
    pick_s = IN_W'(sum_s >>> LOG2D);
`else
    sel_s  = take_s && (phase_q == '0);
    pick_s = din;
`endif
    rq_s = requant(pick_s, clip_s);
  end

  // The new head is the just-pushed sample when it lands in the slot the read pointer moves to.
  always_comb begin
    full_s = (count_q == CNT_W'(FIFO_DEPTH));
    pop_s  = (count_q != '0) && dout_ready;
    push_s = stg_vld_q && (!full_s || pop_s);
    drop_s = stg_vld_q && full_s && !pop_s;
    wr_d   = push_s ? ptr_inc(wr_q) : wr_q;
    rd_d   = pop_s ? ptr_inc(rd_q) : rd_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    head_s = (push_s && (wr_q == rd_d)) ? stg_q : mem_q[rd_d];
    dout_d = (count_d != '0) ? head_s : dout_q;
    sat_d  = (clr_flags ? 1'b0 : sat_q) | (sel_s && clip_s);
    ovf_d  = (clr_flags ? 1'b0 : ovf_q) | drop_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q       <= '0;
      phase_q      <= '0;
      stg_q        <= '0;
      stg_vld_q    <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      warm_q       <= warm_d;
      phase_q      <= phase_d;
      stg_vld_q    <= sel_s;
      if (sel_s) stg_q <= rq_s;
      if (push_s) mem_q[wr_q] <= stg_q;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= (count_d != '0);
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef FIR_OUT_DECIM_AVG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat        = sat_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_out_decim.sv
// Scoreboard bench for fir_out_decim (DECIM=4, WARMUP=16, FIFO_DEPTH=4); honours FIR_OUT_DECIM_AVG_EN.
module tb_fir_out_decim;

  localparam int DECIM = 4;
`ifdef FIR_OUT_DECIM_AVG_EN
  localparam int SEL_OFS = DECIM - 1;
  localparam logic [11:0] WARM_PAT = 12'b0001_0001_0000;
  localparam logic signed [15:0] RAMP_EXP = 16'sd10;
`else
  localparam int SEL_OFS = 0;
  localparam logic [11:0] WARM_PAT = 12'b0010_0010_0010;
  localparam logic signed [15:0] RAMP_EXP = 16'sd4;
`endif

  logic clk = 1'b0;
  logic reset;
  logic signed [31:0] din;
  logic din_valid, dout_ready, clr_flags;
  logic signed [15:0] dout;
  logic dout_valid, sat, overflow;

  int tests_run = 0;
  int fails = 0;
  logic signed [15:0] exp_q [$];

  always #5 clk = ~clk;

  fir_out_decim dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sat(sat), .overflow(overflow), .clr_flags(clr_flags)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic signed [31:0] d);
    din_valid = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic grp(input logic signed [31:0] d);
    repeat (DECIM) tick(1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 32'sd0);
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) idle(1);
    idle(3);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: every accepted output word must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL unexpected_output: got %0d, expected none", dout);
      end else begin
        chk("dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [31:0] rin [5];
    logic signed [15:0] rexp [5];
    logic [11:0] pat;
    int seen;
    rin  = '{32'sh0000_4000, 32'sh0000_3FFF, -32'sd16384, -32'sd16385, 32'sh0000_C000};
    rexp = '{16'sd1, 16'sd0, 16'sd0, -16'sd1, 16'sd2};

    reset = 1'b1; din = 32'sd0; din_valid = 1'b0; dout_ready = 1'b0; clr_flags = 1'b0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ovf", overflow, 0);
    #20;
    @(posedge clk); #1;
    reset = 1'b0;

    // Warm-up, then one output every DECIM samples
    dout_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 32'sh0010_0000);
      seen += int'(dout_valid);
    end
    chk("warmup_quiet", seen, 0);
    repeat (3) exp_q.push_back(16'sd32);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 32'sh0010_0000);
      pat[i] = dout_valid;
    end
    chk("decim_pattern", 32'(pat), 32'(WARM_PAT));
    drain();
    chk("sat_clean", sat, 0);

    // Rounding
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(rexp[i]);
      grp(rin[i]);
    end
    drain();
    chk("round_ovf", overflow, 0);
    chk("round_sat", sat, 0);

    // Saturation and flag clearing
    exp_q.push_back(16'sd32767);
    grp(32'sh7FFF_FFFF);
    idle(2);
    chk("sat_pos", sat, 1);
    exp_q.push_back(-16'sd32768);
    grp(32'sh8000_0000);
    drain();
    clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
    chk("sat_cleared", sat, 0);
    exp_q.push_back(16'sd32767);
    for (int j = 0; j < DECIM; j++) begin
      clr_flags = (j == SEL_OFS);
      tick(1'b1, 32'sh7FFF_FFFF);
    end
    clr_flags = 1'b0;
    idle(1);
    chk("sat_set_wins", sat, 1);
    drain();
    clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
    chk("sat_cleared2", sat, 0);

    // Backpressure and overflow
    dout_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      if (n <= 4) exp_q.push_back(16'(n));
      grp(n * 32768);
      idle(2);
      if (n == 4) chk("ovf_when_full", overflow, 0);
      if (n == 5) chk("ovf_after_drop", overflow, 1);
    end
    chk("hold_head", dout, 1);
    chk("hold_valid", dout_valid, 1);
    drain();
    chk("empty_valid", dout_valid, 0);
    chk("empty_hold_dout", dout, 4);
    clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with simultaneous pop
    dout_ready = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      exp_q.push_back(16'(n));
      grp(n * 32768);
    end
    idle(2);
    exp_q.push_back(16'sd5);
    for (int j = 0; j < 6; j++) begin
      dout_ready = (j == SEL_OFS + 1);
      tick(j < 4, 32'sd5 * 32768);
    end
    dout_ready = 1'b0;
    idle(1);
    chk("pushpop_ovf", overflow, 0);
    chk("pushpop_head", dout, 2);
    drain();

    // Reset mid-stream
    dout_ready = 1'b0;
    grp(32'sd7 * 32768);
    grp(32'sd8 * 32768);
    grp(32'sd9 * 32768);
    grp(32'sh7FFF_FFFF);
    grp(32'sd10 * 32768);
    idle(2);
    chk("pre_rst_ovf", overflow, 1);
    chk("pre_rst_sat", sat, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_sat", sat, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    dout_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 32'sh7FFF_FFFF);
      seen += int'(dout_valid);
    end
    idle(2);
    seen += int'(dout_valid);
    chk("rewarm_quiet", seen, 0);
    chk("rewarm_sat", sat, 0);
    exp_q.push_back(16'sd64);
    grp(32'sh0020_0000);
    drain();

    // Ramp group: averaged to 10, or first sample (4) when picking
    exp_q.push_back(RAMP_EXP);
    tick(1'b1, 32'sd4 * 32768);
    tick(1'b1, 32'sd8 * 32768);
    tick(1'b1, 32'sd12 * 32768);
    tick(1'b1, 32'sd16 * 32768);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
